// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the pipeline control slice.
//   ctrl_state_e     : control FSM encoding (RUN / MEM_WAIT / HALT)
//   DEFAULT_TIMEOUT  : default number of MEM_WAIT cycles tolerated before HALT
// ---------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_e;

  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   i_clk    : clock, rising edge
//   i_arst_n : asynchronous active-low clear
//   i_inc    : add one this cycle (ignored once saturated)
//   o_cnt    : current count, W bits
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_arst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != CNT_MAX)) begin
      o_cnt <= o_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and stall controller for a 5-stage in-order pipeline.
// Detects load-use hazards, applies EX-resolved redirects, freezes the whole
// pipeline while a data-memory access is outstanding and halts for good if the
// memory does not answer within TIMEOUT wait cycles.
// Ports:
//   i_clk, i_arst_n            : clock (rising edge), async active-low reset
//   i_id_rs1_addr/rs2_addr     : source registers of the ID instruction
//   i_id_rs1_used/rs2_used     : the ID instruction actually reads rs1 / rs2
//   i_ex_rd_addr               : destination register of the EX instruction
//   i_ex_mem_read              : the EX instruction is a load
//   i_ex_redirect              : taken branch / JAL / JALR resolved in EX
//   i_mem_req, i_mem_ready     : MEM-stage access request / completion
//   o_pc_stall .. o_ex_mem_stall : hold PC / stage registers
//   o_if_id_flush, o_id_ex_flush : load a bubble into IF/ID / ID/EX
//   o_mem_wb_bubble            : write a bubble into MEM/WB
//   o_state                    : current FSM state
//   o_stall_cnt, o_flush_cnt   : saturating performance counters
//   o_mem_timeout              : sticky memory-timeout flag
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_redirect,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_stall,
  output logic             o_if_id_stall,
  output logic             o_id_ex_stall,
  output logic             o_ex_mem_stall,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_mem_wb_bubble,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic             o_mem_timeout
);

  // The wait counter only has to reach TIMEOUT-1, so size it for that value.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  ctrl_state_e       state;
  ctrl_state_e       state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;

  logic lu;
  logic mm;
  logic wait_done;
  logic freeze;
  logic redirect_apply;
  logic lu_apply;

  // x0 is hard-wired to zero, so a load targeting it can never cause a hazard.
  assign lu = i_ex_mem_read && (i_ex_rd_addr != 5'd0) &&
              ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
               (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));

  assign mm        = i_mem_req && !i_mem_ready;
  assign wait_done = (wait_cnt == WAIT_LAST);

  // Next-state logic: HALT is a trap only reset can release.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mm) state_nxt = MEM_WAIT;
      MEM_WAIT: begin
        if (i_mem_ready)    state_nxt = RUN;
        else if (wait_done) state_nxt = HALT;
      end
      HALT:     state_nxt = HALT;
      default:  state_nxt = RUN;
    endcase
  end

  // State register, wait counter and sticky timeout flag. The wait counter
  // starts from zero on entry so the first MEM_WAIT cycle counts as cycle 0.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == RUN) && (state_nxt == MEM_WAIT)) begin
        wait_cnt <= '0;
      end else if ((state == MEM_WAIT) && !wait_done) begin
        wait_cnt <= wait_cnt + WAIT_ONE;
      end
      if ((state == MEM_WAIT) && (state_nxt == HALT)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Freeze covers the miss cycle in RUN, every unanswered wait cycle and all
  // of HALT. The cycle in which memory answers is a normal cycle, so a
  // redirect or load-use held across the wait is applied exactly then.
  always_comb begin
    freeze = 1'b0;
    case (state)
      RUN:      freeze = mm;
      MEM_WAIT: freeze = !i_mem_ready;
      HALT:     freeze = 1'b1;
      default:  freeze = 1'b0;
    endcase
  end

  // Priority: freeze, then redirect (it discards the ID instruction, which
  // makes any load-use on it moot), then load-use.
  assign redirect_apply = !freeze && i_ex_redirect;
  assign lu_apply       = !freeze && !i_ex_redirect && lu;

  // Control outputs are gated by reset so nothing moves while it is held.
  always_comb begin
    o_pc_stall      = 1'b0;
    o_if_id_stall   = 1'b0;
    o_id_ex_stall   = 1'b0;
    o_ex_mem_stall  = 1'b0;
    o_if_id_flush   = 1'b0;
    o_id_ex_flush   = 1'b0;
    o_mem_wb_bubble = 1'b0;
    if (i_arst_n) begin
      if (freeze) begin
        o_pc_stall      = 1'b1;
        o_if_id_stall   = 1'b1;
        o_id_ex_stall   = 1'b1;
        o_ex_mem_stall  = 1'b1;
        o_mem_wb_bubble = 1'b1;
      end else if (redirect_apply) begin
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
      end else if (lu_apply) begin
        o_pc_stall    = 1'b1;
        o_if_id_stall = 1'b1;
        o_id_ex_flush = 1'b1;
      end
    end
  end

  assign o_state       = state;
  assign o_mem_timeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_inc    (freeze || lu_apply),
    .o_cnt    (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_inc    (redirect_apply),
    .o_cnt    (o_flush_cnt)
  );

endmodule
